// File: rtl/iiitb_rv32i_trace.sv
// Retirement-trace capture for the iiitb_rv32i core: records {seq, pc, wb} whenever the PC changes
// and queues the entries in a first-word-fall-through FIFO drained over a valid/ready port.
module iiitb_rv32i_trace #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] wb_in,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_pc,
    output logic [DW-1:0] rd_wb,
    output logic [15:0]   rd_seq,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);

    // Read handshake: the head entry moves out on any edge where rd_valid and rd_ready are both
    // high; rd_valid and the head data depend only on registered state, never on rd_ready.

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [15:0]   seq;
        logic [DW-1:0] pc;
        logic [DW-1:0] wb;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d;
    logic          first_q, first_d;
    logic [DW-1:0] pc_q, pc_d;
    logic          ev, pop, push, drop;
    entry_t        head;

    assign head     = mem_q[rd_ptr_q];
    assign rd_valid = (level_q != '0);
    assign rd_pc    = head.pc;
    assign rd_wb    = head.wb;
    assign rd_seq   = head.seq;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        ev   = en & (first_q | (pc_in != pc_q));
        pop  = rd_valid & rd_ready;
        // A full FIFO still accepts an event when the head leaves in the same cycle.
        push = ev & ((level_q != DEPTH_L) | pop);
        drop = ev & ~push;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        seq_d      = seq_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q | drop;
        first_d    = first_q;
        pc_d       = pc_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;

        // Dropped events still consume a sequence number so gaps reveal losses.
        if (ev) seq_d = seq_q + 1'b1;

        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 1'b1;

        if (en) begin
            pc_d    = pc_in;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            first_q    <= 1'b1;
            pc_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            first_q    <= first_d;
            pc_q       <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clear) begin
            mem_q[wr_ptr_q] <= '{seq: seq_q, pc: pc_in, wb: wb_in};
        end
    end

endmodule

// File: tb/tb_iiitb_rv32i_trace.sv
// Self-checking bench for iiitb_rv32i_trace: directed vector table, hand-written FIFO corner
// sequences, and randomized traffic compared against a queue-based reference model.
module tb_iiitb_rv32i_trace;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst, en, clear, rd_ready;
    logic [DW-1:0] pc_in, wb_in;
    logic          rd_valid;
    logic [DW-1:0] rd_pc, rd_wb;
    logic [15:0]   rd_seq;
    logic [AW:0]   level;
    logic          overflow;
    logic [15:0]   drop_cnt;

    int n_total = 0;
    int n_pass  = 0;

    iiitb_rv32i_trace #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (clear),
        .pc_in    (pc_in),
        .wb_in    (wb_in),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_pc    (rd_pc),
        .rd_wb    (rd_wb),
        .rd_seq   (rd_seq),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO is a plain queue; events follow the PC-change rule directly.
    typedef struct {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] wb;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_last_pc;
    bit          m_first;
    int          m_seq;
    bit          m_ovf;
    int          m_drop;

    task automatic model_step(input logic r, input logic c, input logic e, input logic rdy,
                              input logic [31:0] pc, input logic [31:0] wb);
        bit   did_pop;
        bit   event_now;
        ent_t ent;
        if (r || c) begin
            m_q.delete();
            m_last_pc = 0;
            m_first   = 1;
            m_seq     = 0;
            m_ovf     = 0;
            m_drop    = 0;
        end else begin
            did_pop   = (m_q.size() != 0) && rdy;
            event_now = e && (m_first || (pc != m_last_pc));
            if (e) begin
                m_last_pc = pc;
                m_first   = 0;
            end
            if (did_pop) void'(m_q.pop_front());
            if (event_now) begin
                if (m_q.size() < DEPTH) begin
                    ent.seq = m_seq[15:0];
                    ent.pc  = pc;
                    ent.wb  = wb;
                    m_q.push_back(ent);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                m_seq = (m_seq + 1) % 65536;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive inputs, clock one rising edge, return at the following falling edge.
    task automatic apply(input logic r, input logic c, input logic e, input logic rdy,
                         input logic [31:0] pc, input logic [31:0] wb);
        rst = r; clear = c; en = e; rd_ready = rdy; pc_in = pc; wb_in = wb;
        model_step(r, c, e, rdy, pc, wb);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".level"},    32'(level),    32'(m_q.size()));
        check({tag, ".valid"},    32'(rd_valid), 32'(m_q.size() != 0));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        if (m_q.size() != 0) begin
            check({tag, ".seq"}, 32'(rd_seq), 32'(m_q[0].seq));
            check({tag, ".pc"},  rd_pc,       m_q[0].pc);
            check({tag, ".wb"},  rd_wb,       m_q[0].wb);
        end
    endtask

    typedef struct {
        logic        rst, clr, en, rdy;
        logic [31:0] pc, wb;
        int          e_level;
        logic        e_valid, e_ovf;
        int          e_drop;
        int          e_seq;
        logic [31:0] e_pc, e_wb;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic c, input logic e, input logic rdy,
                                input logic [31:0] pc, input logic [31:0] wb,
                                input int lvl, input logic v, input logic ov, input int dr,
                                input int sq, input logic [31:0] hpc, input logic [31:0] hwb);
        vec_t t;
        t.rst = r; t.clr = c; t.en = e; t.rdy = rdy; t.pc = pc; t.wb = wb;
        t.e_level = lvl; t.e_valid = v; t.e_ovf = ov; t.e_drop = dr;
        t.e_seq = sq; t.e_pc = hpc; t.e_wb = hwb;
        return t;
    endfunction

    vec_t vecs[17];

    initial begin
        // reset with pc_in=8
        vecs[0]  = mk(1,0,0,0, 32'h8,   0,   0,0,0,0, 0,0,0);
        vecs[1]  = mk(1,0,0,0, 32'h8,   0,   0,0,0,0, 0,0,0);
        // first capture: 0,0,0,4 -> two entries
        vecs[2]  = mk(0,0,1,0, 32'h0,   5,   1,1,0,0, 0,32'h0,5);
        vecs[3]  = mk(0,0,1,0, 32'h0,   5,   1,1,0,0, 0,32'h0,5);
        vecs[4]  = mk(0,0,1,0, 32'h0,   5,   1,1,0,0, 0,32'h0,5);
        vecs[5]  = mk(0,0,1,0, 32'h4,   9,   2,1,0,0, 0,32'h0,5);
        vecs[6]  = mk(0,0,0,1, 32'h4,   9,   1,1,0,0, 1,32'h4,9);
        vecs[7]  = mk(0,0,0,1, 32'h4,   9,   0,0,0,0, 0,0,0);
        vecs[8]  = mk(0,1,0,0, 32'h0,   0,   0,0,0,0, 0,0,0);
        // branch/loop with continuous draining
        vecs[9]  = mk(0,0,1,1, 32'h0,   100, 1,1,0,0, 0,32'h0,100);
        vecs[10] = mk(0,0,1,1, 32'h4,   101, 1,1,0,0, 1,32'h4,101);
        vecs[11] = mk(0,0,1,1, 32'h8,   102, 1,1,0,0, 2,32'h8,102);
        vecs[12] = mk(0,0,1,1, 32'h68,  103, 1,1,0,0, 3,32'h68,103);
        vecs[13] = mk(0,0,1,1, 32'h68,  104, 0,0,0,0, 0,0,0);
        vecs[14] = mk(0,0,1,1, 32'h6C,  105, 1,1,0,0, 4,32'h6C,105);
        vecs[15] = mk(0,0,1,1, 32'hC4,  106, 1,1,0,0, 5,32'hC4,106);
        vecs[16] = mk(0,0,0,1, 32'hC4,  106, 0,0,0,0, 0,0,0);

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].rdy, vecs[i].pc, vecs[i].wb);
            check($sformatf("vec%0d.level", i),    32'(level),    32'(vecs[i].e_level));
            check($sformatf("vec%0d.valid", i),    32'(rd_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            check($sformatf("vec%0d.drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d.seq", i), 32'(rd_seq), 32'(vecs[i].e_seq));
                check($sformatf("vec%0d.pc", i),  rd_pc,       vecs[i].e_pc);
                check($sformatf("vec%0d.wb", i),  rd_wb,       vecs[i].e_wb);
            end
        end

        // Overflow: 20 distinct PCs into a 16-deep FIFO with no draining.
        apply(0,1,0,0, 0, 0);
        for (int i = 0; i < 20; i++) apply(0,0,1,0, 32'h1000 + 4*i, i);
        check("ovf.level",    32'(level),    32'd16);
        check("ovf.overflow", 32'(overflow), 32'd1);
        check("ovf.drop_cnt", 32'(drop_cnt), 32'd4);
        check("ovf.valid",    32'(rd_valid), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf.drain%0d.seq", i), 32'(rd_seq), 32'(i));
            check($sformatf("ovf.drain%0d.pc", i),  rd_pc,       32'h1000 + 4*i);
            apply(0,0,0,1, 0, 0);
        end
        check("ovf.empty", 32'(level), 32'd0);
        apply(0,0,1,0, 32'h2000, 32'hAB);
        check("ovf.next.seq",   32'(rd_seq),   32'd20);
        check("ovf.next.level", 32'(level),    32'd1);
        check("ovf.next.drop",  32'(drop_cnt), 32'd4);

        // Full FIFO with a pop and a new event on the same edges.
        apply(0,1,0,0, 0, 0);
        for (int i = 0; i < 16; i++) apply(0,0,1,0, 32'h3000 + 4*i, i);
        check("full.level", 32'(level), 32'd16);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full.pop%0d.seq", i), 32'(rd_seq), 32'(i));
            apply(0,0,1,1, 32'h3100 + 4*i, 32'h50 + i);
            check($sformatf("full.pop%0d.level", i), 32'(level),    32'd16);
            check($sformatf("full.pop%0d.drop", i),  32'(drop_cnt), 32'd0);
        end
        check("full.head.seq", 32'(rd_seq), 32'd5);

        // Clear mid-stream with an event and a pop pending.
        apply(0,0,1,0, 32'h3200, 0);
        for (int i = 0; i < 9; i++) apply(0,0,0,1, 0, 0);
        check("clr.pre.level",    32'(level),    32'd7);
        check("clr.pre.overflow", 32'(overflow), 32'd1);
        apply(0,1,1,1, 32'h3300, 32'h66);
        check("clr.level",    32'(level),    32'd0);
        check("clr.overflow", 32'(overflow), 32'd0);
        check("clr.drop_cnt", 32'(drop_cnt), 32'd0);
        check("clr.valid",    32'(rd_valid), 32'd0);
        apply(0,0,1,0, 32'h0, 32'h77);
        check("clr.first.level", 32'(level),  32'd1);
        check("clr.first.seq",   32'(rd_seq), 32'd0);
        check("clr.first.pc",    rd_pc,       32'h0);
        check("clr.first.wb",    rd_wb,       32'h77);

        // Randomized traffic against the reference model.
        apply(0,1,0,0, 0, 0);
        check_model("rnd.start");
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic r_en, r_rdy, r_clr, r_rst;
            int   rdy_pct;
            rdy_pct = ((cyc / 100) % 2 == 1) ? 15 : 70;
            r_en  = ($urandom_range(0, 99) < 80);
            r_rdy = ($urandom_range(0, 99) < rdy_pct);
            r_clr = ($urandom_range(0, 199) == 0);
            r_rst = ($urandom_range(0, 499) == 0);
            apply(r_rst, r_clr, r_en, r_rdy, 32'($urandom_range(0, 5)) * 4, $urandom);
            check_model($sformatf("rnd%0d", cyc));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
